// File: rtl/epu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : epu_mul_arbiter
// Brief    : Round-robin issue/wait/return sequencer that shares one
//            multi-cycle fe_mulx multiplier among NUM_CLIENTS engines,
//            with a watchdog for a multiplier that never signals done.
// Revision : 1.0 - initial release
// ============================================================================
module epu_mul_arbiter #(
    parameter int  NUM_CLIENTS = 2,
    parameter int  WIDTH       = 320,
    parameter int  TIMEOUT     = 1024,
    localparam int c_OWNER_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CLIENTS-1:0]       cli_req,
    input  logic [NUM_CLIENTS*WIDTH-1:0] cli_op_a,
    input  logic [NUM_CLIENTS*WIDTH-1:0] cli_op_b,
    output logic [NUM_CLIENTS-1:0]       cli_gnt,
    output logic [NUM_CLIENTS-1:0]       cli_done,
    output logic [NUM_CLIENTS-1:0]       cli_err,
    output logic [WIDTH-1:0]             cli_res,
    output logic [WIDTH-1:0]             mul_op_a,
    output logic [WIDTH-1:0]             mul_op_b,
    output logic                         mul_valid,
    input  logic [WIDTH-1:0]             mul_res,
    input  logic                         mul_done,
    output logic                         busy,
    output logic [c_OWNER_W-1:0]         owner
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ISSUE  = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_RETURN = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_OWNER_W-1:0] r_last;
    logic [c_OWNER_W-1:0] r_owner;
    logic [c_OWNER_W-1:0] w_pick;
    logic [c_OWNER_W-1:0] w_cand;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic [WIDTH-1:0]     r_res;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_err;
    logic                 w_timeout;
    logic                 w_any_req;
    logic [WIDTH-1:0]     w_op_a [NUM_CLIENTS];
    logic [WIDTH-1:0]     w_op_b [NUM_CLIENTS];

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign w_op_a[gi] = cli_op_a[gi*WIDTH +: WIDTH];
            assign w_op_b[gi] = cli_op_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_any_req = |cli_req;

    // Scan from farthest to nearest after r_last so the nearest requester wins.
    always_comb begin
        w_pick = r_last;
        w_cand = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            w_cand = c_OWNER_W'((int'(r_last) + k) % NUM_CLIENTS);
            if (cli_req[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (w_any_req) w_next_state = c_S_ISSUE;
            c_S_ISSUE:  w_next_state = c_S_WAIT;
            c_S_WAIT:   if (mul_done || w_timeout) w_next_state = c_S_RETURN;
            c_S_RETURN: w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        cli_gnt   = '0;
        cli_done  = '0;
        cli_err   = '0;
        mul_valid = 1'b0;
        case (r_state)
            c_S_ISSUE: begin
                cli_gnt[r_owner] = 1'b1;
                mul_valid        = 1'b1;
            end
            c_S_RETURN: begin
                cli_done[r_owner] = 1'b1;
                cli_err[r_owner]  = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= c_OWNER_W'(NUM_CLIENTS - 1);
            r_owner <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_op_a  <= w_op_a[w_pick];
                        r_op_b  <= w_op_b[w_pick];
                    end
                end
                c_S_ISSUE: r_cnt <= '0;
                c_S_WAIT: begin
                    // A real done wins over a watchdog expiry in the same cycle.
                    if (mul_done) begin
                        r_res <= mul_res;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != c_S_IDLE);
    assign owner    = r_owner;
    assign cli_res  = r_res;
    assign mul_op_a = r_op_a;
    assign mul_op_b = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_epu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_epu_mul_arbiter
// Brief    : Directed self-checking bench for epu_mul_arbiter with a
//            transaction-level timing model and a modular-multiply stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_epu_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 320;
    localparam int TO = 16;
    localparam logic [W-1:0] P = (320'd1 << 255) - 320'd19;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   cli_req;
    logic [N*W-1:0] cli_op_a;
    logic [N*W-1:0] cli_op_b;
    logic [N-1:0]   cli_gnt;
    logic [N-1:0]   cli_done;
    logic [N-1:0]   cli_err;
    logic [W-1:0]   cli_res;
    logic [W-1:0]   mul_op_a;
    logic [W-1:0]   mul_op_b;
    logic           mul_valid;
    logic [W-1:0]   mul_res;
    logic           mul_done;
    logic           busy;
    logic [1:0]     owner;

    epu_mul_arbiter #(.NUM_CLIENTS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cli_req(cli_req), .cli_op_a(cli_op_a), .cli_op_b(cli_op_b),
        .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_err(cli_err), .cli_res(cli_res),
        .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_valid(mul_valid),
        .mul_res(mul_res), .mul_done(mul_done),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p % (2*W)'(P);
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Client programs: each client walks its table, holding req while ops remain.
    logic [W-1:0] tab_a [N][8];
    logic [W-1:0] tab_b [N][8];
    int           idx   [N];
    int           total [N];
    int           start [N];
    logic [N-1:0] gnt_seen = '0;
    logic         mv_seen  = 1'b0;

    // Multiplier stub: done mul_lat cycles after mul_valid, mul_lat==0 means never.
    int           mul_lat = 5;
    logic         pend = 1'b0;
    logic [W-1:0] pa, pb;
    int           done_at = 0;
    logic         inject_done = 1'b0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) idx[i] = idx[i] + 1;
            if (idx[i] < total[i] && cyc >= start[i]) begin
                cli_req[i]          = 1'b1;
                cli_op_a[i*W +: W]  = tab_a[i][idx[i]];
                cli_op_b[i*W +: W]  = tab_b[i][idx[i]];
            end else begin
                cli_req[i]          = 1'b0;
                cli_op_a[i*W +: W]  = rnd_w();
                cli_op_b[i*W +: W]  = rnd_w();
            end
        end
        if (rst) begin
            pend = 1'b0;
        end else if (mv_seen) begin
            pend    = 1'b1;
            pa      = mul_op_a;
            pb      = mul_op_b;
            done_at = cyc - 1 + mul_lat;
        end
        if (pend && mul_lat != 0 && cyc == done_at) begin
            mul_done = 1'b1;
            mul_res  = fmul(pa, pb);
            pend     = 1'b0;
        end else begin
            mul_done = inject_done;
            mul_res  = rnd_w();
        end
        inject_done = 1'b0;
    end

    // Transaction-level model: a selection at cycle c implies gnt at c+1 and
    // the result at c+2+min(latency, TO); the arbiter is free again one cycle later.
    int           m_sel = -100, m_res_cyc = -100, m_free = 0;
    int           m_last = N - 1, m_owner = 0, m_pick;
    logic [W-1:0] m_a = '0, m_b = '0, m_res_vis = '0, m_res_pend = '0;
    logic         m_err = 1'b0, m_found;
    logic [N-1:0] e_oh;
    int           order_code = 0, done_count = 0;
    int           last_gnt_cyc = -1, last_done_cyc = -1;
    logic [W-1:0] last_done_res = '0;
    logic         last_done_err = 1'b0;

    always @(negedge clk) begin
        gnt_seen = cli_gnt;
        mv_seen  = mul_valid;
        if (rst) begin
            m_sel = -100; m_res_cyc = -100; m_free = 0; m_last = N - 1; m_owner = 0;
            m_a = '0; m_b = '0; m_res_vis = '0; m_res_pend = '0; m_err = 1'b0;
        end else begin
            if (cyc == m_res_cyc) m_res_vis = m_res_pend;
            e_oh = N'(1) << m_owner;
            chk("gnt",       W'(cli_gnt),   W'((cyc == m_sel + 1) ? e_oh : '0));
            chk("mul_valid", W'(mul_valid), W'(cyc == m_sel + 1));
            chk("done",      W'(cli_done),  W'((cyc == m_res_cyc) ? e_oh : '0));
            chk("err",       W'(cli_err),   W'((cyc == m_res_cyc && m_err) ? e_oh : '0));
            chk("busy",      W'(busy),      W'(cyc > m_sel && cyc <= m_res_cyc));
            chk("owner",     W'(owner),     W'(m_owner));
            chk("mul_op_a",  mul_op_a,      m_a);
            chk("mul_op_b",  mul_op_b,      m_b);
            chk("cli_res",   cli_res,       m_res_vis);
            for (int i = 0; i < N; i++) begin
                if (cli_gnt[i]) begin
                    order_code   = order_code * 10 + i + 1;
                    last_gnt_cyc = cyc;
                end
            end
            if (cli_done != '0) begin
                done_count++;
                last_done_cyc = cyc;
                last_done_res = cli_res;
                last_done_err = |cli_err;
            end
            if (cyc >= m_free && cli_req != '0) begin
                m_found = 1'b0;
                m_pick  = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!m_found && cli_req[(m_last + k) % N]) begin
                        m_pick  = (m_last + k) % N;
                        m_found = 1'b1;
                    end
                end
                m_sel      = cyc;
                m_owner    = m_pick;
                m_last     = m_pick;
                m_a        = cli_op_a[m_pick*W +: W];
                m_b        = cli_op_b[m_pick*W +: W];
                m_err      = (mul_lat == 0 || mul_lat > TO);
                m_res_cyc  = cyc + 2 + (m_err ? TO : mul_lat);
                m_free     = m_res_cyc + 1;
                m_res_pend = m_err ? '0 : fmul(m_a, m_b);
            end
        end
    end

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            idx[i] = 0; total[i] = 0; start[i] = 0;
        end
        order_code = 0;
        done_count = 0;
    endtask

    task automatic add_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        tab_a[i][total[i]] = a;
        tab_b[i][total[i]] = b;
        total[i]           = total[i] + 1;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (idx[i] < total[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (!busy && !pending()) ? quiet + 1 : 0;
        end
        chk("idle_within_budget", W'(quiet >= 3), W'(1));
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) total[i] = idx[i];
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        clear_clients();
    endtask

    initial begin
        cli_req = '0; cli_op_a = '0; cli_op_b = '0; mul_res = '0; mul_done = 1'b0;
        clear_clients();
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",  W'(busy),     W'(0));
        chk("rst_gnt",   W'(cli_gnt),  W'(0));
        chk("rst_valid", W'(mul_valid), W'(0));
        chk("rst_owner", W'(owner),    W'(0));
        chk("rst_res",   cli_res,      W'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;

        // Single op from client 0, req rising at cycle 10, multiplier latency 5.
        mul_lat  = 5;
        start[0] = 10;
        add_op(0, W'(2), W'(3));
        wait_idle(100);
        chk("p1_gnt_cycle",  W'(last_gnt_cyc),  W'(11));
        chk("p1_done_cycle", W'(last_done_cyc), W'(17));
        chk("p1_result",     last_done_res,     W'(6));
        chk("p1_err",        W'(last_done_err), W'(0));

        // Two clients requesting continuously, three ops each.
        do_reset();
        add_op(0, W'(100), W'(7));
        add_op(0, P - W'(1), W'(2));
        add_op(0, W'(11), W'(13));
        add_op(1, W'(200), W'(9));
        add_op(1, W'(12345), W'(6789));
        add_op(1, P - W'(5), P - W'(5));
        wait_idle(200);
        chk("p2_order", W'(order_code), W'(121212));
        chk("p2_dones", W'(done_count), W'(6));

        // Only clients 1 and 3 requesting.
        do_reset();
        add_op(1, W'(3), W'(5));
        add_op(1, W'(6), W'(7));
        add_op(3, W'(8), W'(9));
        add_op(3, W'(10), W'(11));
        wait_idle(200);
        chk("p3_order", W'(order_code), W'(2424));

        // Client 2 joins late and overtakes client 3 after client 1 is served.
        do_reset();
        add_op(1, W'(21), W'(22));
        add_op(1, W'(23), W'(24));
        add_op(3, W'(31), W'(32));
        add_op(3, W'(33), W'(34));
        start[2] = cyc + 3;
        add_op(2, W'(41), W'(42));
        wait_idle(200);
        chk("p3b_order", W'(order_code), W'(23424));

        // Watchdog: multiplier never answers.
        do_reset();
        mul_lat = 0;
        add_op(2, W'(5), W'(5));
        wait_idle(200);
        chk("to_latency", W'(last_done_cyc - last_gnt_cyc), W'(TO + 1));
        chk("to_err",     W'(last_done_err), W'(1));
        chk("to_res",     last_done_res,     W'(0));
        @(negedge clk); #2;
        inject_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_done_busy", W'(busy), W'(0));
        #2;
        clear_clients();
        mul_lat = 5;
        add_op(0, W'(3), W'(4));
        wait_idle(100);
        chk("recover_res", last_done_res,     W'(12));
        chk("recover_err", W'(last_done_err), W'(0));

        // Asynchronous reset in the middle of a long WAIT.
        @(negedge clk); #2;
        clear_clients();
        mul_lat = 10;
        add_op(0, W'(9), W'(9));
        begin
            int n = 0;
            while (!cli_gnt[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("async_gnt_seen", W'(cli_gnt[0]), W'(1));
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_busy",  W'(busy),      W'(0));
        chk("async_owner", W'(owner),     W'(0));
        chk("async_done",  W'(cli_done),  W'(0));
        chk("async_res",   cli_res,       W'(0));
        chk("async_op_a",  mul_op_a,      W'(0));
        chk("async_op_b",  mul_op_b,      W'(0));
        @(negedge clk); #2;
        clear_clients();
        mul_lat = 5;
        add_op(0, W'(2), W'(5));
        add_op(1, W'(3), W'(3));
        @(posedge clk);
        #2 rst = 1'b0;
        wait_idle(100);
        chk("async_order", W'(order_code), W'(12));
        chk("async_dones", W'(done_count), W'(2));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
